// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: single-cycle req/ack transfer
// with the fetch address and the returned instruction word.
interface fetch_unit_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage driving the IF/ID latch: PC, imem req/ack, redirects, stalls.
// Define FETCH_SKID_EN to add a one-entry skid buffer that keeps fetching through a stall.
module fetch_unit #(
  parameter int              PC_W     = 7,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               stop,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    next_pc_out,
  output logic               ena_out,
  output logic               bubble_out
);

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            req;
  logic            xfer;

  assign pc_inc = pc + PC_W'(1);

`ifdef FETCH_SKID_EN
  logic               skid_full_p1;
  logic [INSTR_W-1:0] skid_instr_p1;
  logic [PC_W-1:0]    skid_npc_p1;

  assign req = (state == FETCH) && ena && !skid_full_p1;
`else
  // Remembers that the last cycle was stalled, so the restart request lands one cycle later.
  logic stall_p1;

  assign req = (state == FETCH) && ena && !(ena_out && stop) && !stall_p1;
`endif

  assign xfer           = req && imem.imem_ack;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Stage boundary: fetch -> IF/ID output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      instruction_out <= '0;
      next_pc_out     <= '0;
      ena_out         <= 1'b0;
      bubble_out      <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_full_p1    <= 1'b0;
`else
      stall_p1        <= 1'b0;
`endif
    end else if (branch_taken) begin
      state           <= REDIRECT;
      pc              <= branch_target;
      instruction_out <= '0;
      next_pc_out     <= branch_target;
      ena_out         <= 1'b0;
      bubble_out      <= 1'b1;
`ifdef FETCH_SKID_EN
      skid_full_p1    <= 1'b0;
`else
      stall_p1        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:     if (ena) state <= FETCH;
        FETCH:    if (!ena) state <= IDLE;
        REDIRECT: state <= ena ? FETCH : IDLE;
        default:  state <= IDLE;
      endcase

      if (xfer) pc <= pc_inc;

`ifdef FETCH_SKID_EN
      // A held skid entry always drains ahead of fresh memory data.
      if (!stop && skid_full_p1) begin
        instruction_out <= skid_instr_p1;
        next_pc_out     <= skid_npc_p1;
        ena_out         <= 1'b1;
        bubble_out      <= 1'b0;
        skid_full_p1    <= 1'b0;
      end else if (xfer && ena_out && stop) begin
        skid_full_p1    <= 1'b1;
      end else if (xfer) begin
        instruction_out <= imem.imem_rdata;
        next_pc_out     <= pc_inc;
        ena_out         <= 1'b1;
        bubble_out      <= 1'b0;
      end else if (!stop) begin
        ena_out         <= 1'b0;
        bubble_out      <= 1'b0;
      end
`else
      stall_p1 <= ena_out && stop;
      if (xfer) begin
        instruction_out <= imem.imem_rdata;
        next_pc_out     <= pc_inc;
        ena_out         <= 1'b1;
        bubble_out      <= 1'b0;
      end else if (!stop) begin
        ena_out         <= 1'b0;
        bubble_out      <= 1'b0;
      end
`endif
    end
  end

`ifdef FETCH_SKID_EN
  // Stage boundary: fetch -> skid entry (data only, validity is skid_full_p1)
  always_ff @(posedge clk) begin
    if (xfer && ena_out && stop && !branch_taken) begin
      skid_instr_p1 <= imem.imem_rdata;
      skid_npc_p1   <= pc_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an IF/ID latch model pops a queue of expected
// (ena, bubble, instruction, next_pc) entries whenever the latch would capture.
module tb_fetch_unit;
  localparam int PC_W    = 7;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic               stop;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instruction_out;
  logic [PC_W-1:0]    next_pc_out;
  logic               ena_out;
  logic               bubble_out;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] expq[$];

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(7'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .stop            (stop),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem            (bus),
    .instruction_out (instruction_out),
    .next_pc_out     (next_pc_out),
    .ena_out         (ena_out),
    .bubble_out      (bubble_out)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word holds its own address + 0x100.
  assign bus.imem_rdata = 32'h100 + 32'(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outv();
    return {23'd0, ena_out, bubble_out, instruction_out, next_pc_out};
  endfunction

  function automatic logic [63:0] ins(input int p);
    logic [6:0] a;
    logic [6:0] n;
    a = 7'(p);
    n = a + 7'd1;
    return {23'd0, 1'b1, 1'b0, 32'h100 + 32'(a), n};
  endfunction

  function automatic logic [63:0] bub(input logic [6:0] t);
    return {23'd0, 1'b0, 1'b1, 32'd0, t};
  endfunction

  function automatic logic [63:0] bus_v();
    return 64'({bus.imem_req, bus.imem_addr});
  endfunction

  function automatic logic [63:0] req_at(input logic [6:0] a);
    return 64'({1'b1, a});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [6:0] a);
    int n;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && n < 40) begin
      tick();
      n++;
    end
    chk("reach_addr", bus_v(), req_at(a));
  endtask

  // IF/ID latch model: captures on every edge with stop low.
  always @(negedge clk) begin
    if (rst === 1'b0 && stop === 1'b0 && (ena_out || bubble_out)) begin
      if (expq.size() == 0) chk("latch_unexpected", outv(), 64'd0);
      else                  chk("latch", outv(), expq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b0; stop = 1'b0; branch_taken = 1'b0;
    branch_target = '0; bus.imem_ack = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_bus", bus_v(), 64'd0);
    chk("rst_out", outv(), 64'd0);
    tick(); tick();

    // Streaming fetch from PC 0
    rst = 1'b0; ena = 1'b1; bus.imem_ack = 1'b1;
    for (int p = 0; p < 12; p++) expq.push_back(ins(p));
    #1 chk("idle_req", 64'(bus.imem_req), 64'd0);
    tick();
    for (int p = 0; p < 6; p++) begin
      chk("seq_addr", bus_v(), req_at(7'(p)));
      if (p > 0) chk("seq_out", outv(), ins(p - 1));
      tick();
    end

    // Three-cycle stall with PC 5 at the output
    stop = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_out", outv(), ins(5));
`ifdef FETCH_SKID_EN
      chk("stall_req", 64'(bus.imem_req), 64'(c == 0));
`else
      chk("stall_req", 64'(bus.imem_req), 64'd0);
`endif
      tick();
    end
    stop = 1'b0;
    #1;
    chk("restart_req", 64'(bus.imem_req), 64'd0);
    chk("restart_out", outv(), ins(5));
    tick();
`ifdef FETCH_SKID_EN
    chk("restart_addr", bus_v(), req_at(7'd7));
    chk("restart_out1", outv(), ins(6));
`else
    chk("restart_addr", bus_v(), req_at(7'd6));
    chk("restart_out1", 64'(ena_out), 64'd0);
`endif

    // Memory withholds ack for four cycles at PC 9
    wait_addr(7'd9);
    bus.imem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("ackhold_addr", bus_v(), req_at(7'd9));
      if (c > 0) chk("ackhold_ena", 64'(ena_out), 64'd0);
      tick();
    end
    bus.imem_ack = 1'b1;
    tick();
    chk("ack_capture", outv(), ins(9));

    // Redirect to 40 together with stop and a live transfer
    wait_addr(7'd12);
    bus.imem_ack = 1'b0;
    tick();
    bus.imem_ack = 1'b1; stop = 1'b1; branch_taken = 1'b1; branch_target = 7'd40;
    expq.push_back(bub(7'd40));
    expq.push_back(ins(40));
    expq.push_back(ins(41));
    #1 chk("br_xfer", 64'({bus.imem_req, ena_out}), 64'(2'b10));
    tick();
    branch_taken = 1'b0; stop = 1'b0;
    #1;
    chk("br_bubble", outv(), bub(7'd40));
    chk("br_req", 64'(bus.imem_req), 64'd0);
    tick();
    chk("br_target_addr", bus_v(), req_at(7'd40));
    tick(); tick();

    // Redirect to 126, then wrap past 127
    branch_taken = 1'b1; branch_target = 7'd126;
    expq.push_back(bub(7'd126));
    expq.push_back(ins(126));
    expq.push_back(ins(127));
    tick();
    branch_taken = 1'b0;
    #1 chk("wrap_bubble", outv(), bub(7'd126));
    tick();
    chk("wrap_addr126", bus_v(), req_at(7'd126));
    tick();
    chk("wrap_addr127", bus_v(), req_at(7'd127));
    tick();
    chk("wrap_npc", outv(), ins(127));
    chk("wrap_addr0", bus_v(), req_at(7'd0));
    tick();

    // Asynchronous reset between edges while fetching
    #2 rst = 1'b1;
    #1;
    chk("arst_out", outv(), 64'd0);
    chk("arst_bus", bus_v(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    expq.push_back(ins(0));
    #1 chk("rs_idle_req", 64'(bus.imem_req), 64'd0);
    tick();
    chk("rs_addr", bus_v(), req_at(7'd0));
    tick();
    ena = 1'b0;
    #1;
    chk("rs_ena_off", 64'(bus.imem_req), 64'd0);
    chk("rs_out", outv(), ins(0));
    tick(); tick();
    chk("drain_ena", 64'(ena_out), 64'd0);
    chk("drain_queue", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
